// File: rtl/cmp_pkg.sv
// Shared types and reset constants for the cascadable magnitude comparator.
// A result is a {greater, equal} pair travelling from MSB to LSB.
`timescale 1ns/1ps
package cmp_pkg;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_res_t;

  localparam logic CMP_RST_GT = 1'b0;
  localparam logic CMP_RST_EQ = 1'b0;

  function automatic cmp_res_t cmp_rst_val();
    cmp_res_t r;
    r.gt = CMP_RST_GT;
    r.eq = CMP_RST_EQ;
    return r;
  endfunction

endpackage

// File: rtl/cascade_compare_if.sv
// Operand and cascade signals of one comparator stage, grouped for benches and wrappers.
// The master side drives operands and cascade-in; the slave side returns CM/M.
`timescale 1ns/1ps
interface cascade_compare_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             Ei;
  logic             CM;
  logic             M;

  modport master (output A, B, C, Ei, input CM, M);
  modport slave  (input A, B, C, Ei, output CM, M);

endinterface

// File: rtl/cmp_bit_slice.sv
// One bit of the MSB-to-LSB comparison ripple; purely combinational.
// A stage that is still equal decides "greater" when a=1 and b=0.
`timescale 1ns/1ps
module cmp_bit_slice (
  input  logic gt_i,
  input  logic eq_i,
  input  logic a,
  input  logic b,
  output logic gt_o,
  output logic eq_o
);

  assign gt_o = gt_i | (eq_i & a & ~b);
  assign eq_o = eq_i & ~(a ^ b);

endmodule

// File: rtl/cascade_compare_top.sv
// Registered, cascadable unsigned magnitude-comparator slice.
// WIDTH bit slices ripple from MSB to LSB; the LSB result is registered onto CM/M.
`timescale 1ns/1ps
module cascade_compare_top
  import cmp_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             Ei,
  output logic             CM,
  output logic             M
);

  // Index WIDTH is the cascade entry; index 0 is the LSB result.
  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] eq_chain;
  cmp_res_t       res_d;
  cmp_res_t       res_q;

  // Ei has priority: an inconsistent C=1 with Ei=1 must not pre-load "greater".
  assign gt_chain[WIDTH] = C & ~Ei;
  assign eq_chain[WIDTH] = Ei;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    cmp_bit_slice u_slice (
      .gt_i (gt_chain[i+1]),
      .eq_i (eq_chain[i+1]),
      .a    (A[i]),
      .b    (B[i]),
      .gt_o (gt_chain[i]),
      .eq_o (eq_chain[i])
    );
  end

  always_comb begin
    res_d    = cmp_rst_val();
    res_d.gt = gt_chain[0];
    res_d.eq = eq_chain[0];
  end

  // NOTE: non-blocking assignment keeps every flop sampling the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= cmp_rst_val();
    end else begin
      res_q <= res_d;
    end
  end

  assign CM = res_q.gt;
  assign M  = res_q.eq;

endmodule

// File: tb/tb_cascade_compare_top.sv
// Self-checking bench: directed tables, latency/reset sequences and random vectors
// against a plain-arithmetic reference for WIDTH = 1, 4 and 8.
`timescale 1ns/1ps
module tb_cascade_compare_top;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  cascade_compare_if #(.WIDTH(1)) if1 ();
  cascade_compare_if #(.WIDTH(4)) if4 ();
  cascade_compare_if #(.WIDTH(8)) if8 ();

  cascade_compare_top #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(if1.A), .B(if1.B), .C(if1.C), .Ei(if1.Ei),
    .CM(if1.CM), .M(if1.M)
  );
  cascade_compare_top #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(if4.A), .B(if4.B), .C(if4.C), .Ei(if4.Ei),
    .CM(if4.CM), .M(if4.M)
  );
  cascade_compare_top #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(if8.A), .B(if8.B), .C(if8.C), .Ei(if8.Ei),
    .CM(if8.CM), .M(if8.M)
  );

  // 25 MHz lab clock: 40 ns period.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic       ei;
    logic       cm;
    logic       m;
  } vec_t;

  vec_t vecs[10];

  // Reference: Ei=1 compares numbers, otherwise the upper-stage decision passes through.
  function automatic logic [1:0] model(int unsigned a, int unsigned b, logic c, logic ei);
    if (ei) return {logic'(a > b), logic'(a == b)};
    return {c, 1'b0};
  endfunction

  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {CM,M}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{a: 4'b1000, b: 4'b0111, c: 1'b0, ei: 1'b1, cm: 1'b1, m: 1'b0};
    vecs[1] = '{a: 4'b0011, b: 4'b0011, c: 1'b0, ei: 1'b1, cm: 1'b0, m: 1'b1};
    vecs[2] = '{a: 4'b0000, b: 4'b1111, c: 1'b0, ei: 1'b1, cm: 1'b0, m: 1'b0};
    vecs[3] = '{a: 4'b0000, b: 4'b1111, c: 1'b1, ei: 1'b0, cm: 1'b1, m: 1'b0};
    vecs[4] = '{a: 4'b1111, b: 4'b1111, c: 1'b0, ei: 1'b1, cm: 1'b0, m: 1'b1};
    vecs[5] = '{a: 4'b1111, b: 4'b0000, c: 1'b0, ei: 1'b0, cm: 1'b0, m: 1'b0};
    vecs[6] = '{a: 4'b1111, b: 4'b1111, c: 1'b1, ei: 1'b1, cm: 1'b0, m: 1'b1};
    vecs[7] = '{a: 4'b0101, b: 4'b0100, c: 1'b1, ei: 1'b1, cm: 1'b1, m: 1'b0};
    vecs[8] = '{a: 4'b0110, b: 4'b0111, c: 1'b1, ei: 1'b1, cm: 1'b0, m: 1'b0};
    vecs[9] = '{a: 4'b0001, b: 4'b0000, c: 1'b0, ei: 1'b1, cm: 1'b1, m: 1'b0};

    // Reset with all inputs high, checked before the first clock edge.
    rst_n = 1'b1;
    if1.A = '1; if1.B = '1; if1.C = 1'b1; if1.Ei = 1'b1;
    if4.A = '1; if4.B = '1; if4.C = 1'b1; if4.Ei = 1'b1;
    if8.A = '1; if8.B = '1; if8.C = 1'b1; if8.Ei = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    check("reset_pre_edge_w1", {if1.CM, if1.M}, 2'b00);
    check("reset_pre_edge_w4", {if4.CM, if4.M}, 2'b00);
    check("reset_pre_edge_w8", {if8.CM, if8.M}, 2'b00);
    tick();
    tick();
    check("reset_held_w1", {if1.CM, if1.M}, 2'b00);
    check("reset_held_w8", {if8.CM, if8.M}, 2'b00);

    // WIDTH=1 tied-input cases.
    @(negedge clk);
    rst_n = 1'b1;
    if1.A = 1'b0; if1.B = 1'b0; if1.C = 1'b0; if1.Ei = 1'b0;
    tick();
    check("w1_all_zero", {if1.CM, if1.M}, 2'b00);
    if1.A = 1'b1; if1.B = 1'b1; if1.C = 1'b1; if1.Ei = 1'b1;
    tick();
    check("w1_all_one", {if1.CM, if1.M}, 2'b01);
    if1.A = 1'b1; if1.B = 1'b0; if1.C = 1'b0; if1.Ei = 1'b1;
    tick();
    check("w1_gt", {if1.CM, if1.M}, 2'b10);

    // WIDTH=4 directed table.
    for (int i = 0; i < 10; i++) begin
      if4.A = vecs[i].a; if4.B = vecs[i].b; if4.C = vecs[i].c; if4.Ei = vecs[i].ei;
      tick();
      check($sformatf("w4_vec%0d", i), {if4.CM, if4.M}, {vecs[i].cm, vecs[i].m});
    end

    // Latency: a change just after edge k is invisible until edge k+1.
    if4.A = 4'd3; if4.B = 4'd3; if4.C = 1'b0; if4.Ei = 1'b1;
    tick();
    check("lat_equal", {if4.CM, if4.M}, 2'b01);
    if4.A = 4'd8; if4.B = 4'd7;
    @(negedge clk);
    check("lat_hold_before_edge", {if4.CM, if4.M}, 2'b01);
    tick();
    check("lat_update_after_edge", {if4.CM, if4.M}, 2'b10);

    // Mid-stream reset pulse: immediate clear, then resume one edge after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_immediate", {if4.CM, if4.M}, 2'b00);
    tick();
    check("midrst_held_over_edge", {if4.CM, if4.M}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_released_no_edge", {if4.CM, if4.M}, 2'b00);
    tick();
    check("midrst_resume", {if4.CM, if4.M}, 2'b10);

    // Randomized vectors on WIDTH=4 and WIDTH=8, biased to hit equality often.
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  a8, b8;
      logic [3:0]  a4, b4;
      logic        c8, e8, c4, e4;
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
      a4 = 4'($urandom);
      b4 = ($urandom_range(0, 3) == 0) ? a4 : 4'($urandom);
      c8 = 1'($urandom); e8 = ($urandom_range(0, 3) != 0);
      c4 = 1'($urandom); e4 = ($urandom_range(0, 3) != 0);
      if8.A = a8; if8.B = b8; if8.C = c8; if8.Ei = e8;
      if4.A = a4; if4.B = b4; if4.C = c4; if4.Ei = e4;
      tick();
      check($sformatf("rand8_%0d", n), {if8.CM, if8.M}, model(a8, b8, c8, e8));
      check($sformatf("rand4_%0d", n), {if4.CM, if4.M}, model(a4, b4, c4, e4));
      if (if8.CM && if8.M) begin
        checks++;
        errors++;
        $display("FAIL rand8_exclusive_%0d: got CM=1 M=1 required not both", n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
